seg7_counter: RTL and testbench
===============================

Name: seg7_counter

Overview:
- Parametrised up/down event counter for the lab board.
- The low hex digit of the count is shown on the 7-segment display.
- Generalises the fixed switch-to-digit display block:
  - programmable modulus and width
  - prescaled count tick
  - selectable wrap or saturate mode
  - terminal-count pulse and sticky overflow on the decimal point
- Sits in top, driven by SWI, feeding SEG and LED.

Parameters:
- NBITS, 4: counter width in bits.
- MODULUS, 10: count range is 0..MODULUS-1. Requires 2 <= MODULUS <= 2**NBITS.
- DIV, 1: prescaler. A count step is allowed once every DIV clk_2 cycles. DIV >= 1.

Ports:
- clk_2, input, 1: board clock.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: count enable.
- up, input, 1: 1 = count up, 0 = count down.
- sat, input, 1: 1 = saturate at the ends, 0 = wrap.
- load, input, 1: synchronous load of load_val.
- load_val, input, NBITS: value to load.
- count, output, NBITS: current count.
- tc, output, 1: one-cycle pulse on wrap or on an attempted step past an end.
- ovf, output, 1: sticky overflow/underflow flag.
- SEG, output, 8: SEG[6:0] = gfedcba, active-high. SEG[7] = decimal point = ovf.

Behaviour:
- Reset (asynchronous, active-high; the only clock is clk_2):
  - count = 0, tc = 0, ovf = 0, prescaler = 0.
  - SEG = 8'h3F (digit 0, dp off).
- Priority per rising clk_2 edge: reset > load > step.
- Prescaler:
  - Counts 0..DIV-1 while en = 1 and load = 0.
  - tick is asserted when prescaler = DIV-1, and the prescaler then returns to 0.
  - With DIV = 1, tick is asserted every enabled cycle.
  - The prescaler holds while en = 0 and clears on load.
- Load:
  - count <= min(load_val, MODULUS-1); ovf <= 0; tc <= 0.
- Step (en & tick & ~load):
  - up, count < MODULUS-1: count+1.
  - up, count = MODULUS-1, sat = 0: count <= 0; tc pulses; ovf <= 1.
  - up, count = MODULUS-1, sat = 1: count holds; tc pulses; ovf <= 1.
  - down, count > 0: count-1.
  - down, count = 0, sat = 0: count <= MODULUS-1; tc pulses; ovf <= 1.
  - down, count = 0, sat = 1: count holds; tc pulses; ovf <= 1.
- tc:
  - Registered; high for exactly the one cycle after the boundary step. 0 otherwise.
- ovf:
  - Sticky; set by any boundary event. Cleared only by load or reset.
- Direction changes and sat changes:
  - An up/sat change mid-count takes effect on the next tick.
  - The prescaler phase is not disturbed.
- Display:
  - SEG[6:0] is combinational from count[3:0] via the hex decoder.
    - 0..9 use the standard glyphs (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F).
    - A..F = 77, 7C, 39, 5E, 79, 71.
  - If NBITS < 4, zero-extend count.
  - If NBITS > 4, only the low nibble is displayed.
  - SEG[7] = ovf.
- Arithmetic:
  - All comparisons are unsigned at NBITS width.
  - No intermediate overflow: boundary tests precede the +1/-1.
- Reset asserted mid-count clears everything immediately, independent of clk_2.
- Release of reset: counting resumes on the first edge with en = 1. The prescaler starts from 0.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant array (logic [6:0]);
  - the constant SEG_BLANK = 8'h00;
  - an enum count_mode_t {WRAP, SATURATE} used to interpret sat.
- Sub-module seg7_decoder: combinational, input [3:0] hex, input dp, output [7:0] seg.
  - Reused later by multi-digit display blocks.
- Counter and prescaler stay in seg7_counter.

Test Plan:
- Reset and load: reset pulse mid-count with count = 7.
  - count = 0, SEG = 8'h3F, ovf = 0 asynchronously, before the next edge.
- Wrap up: MODULUS = 10, DIV = 1, sat = 0, up = 1, en = 1 from 0 for 10 cycles.
  - count runs 1..9 then 0.
  - tc high for one cycle after the 9->0 step.
  - ovf = 1 and SEG = 8'hBF.
- Saturate down: sat = 1, up = 0, load_val = 2, load, then 4 enabled cycles.
  - count runs 1, 0, 0, 0.
  - tc pulses on the first blocked step.
  - ovf = 1; count never shows 9.
- Prescaler: DIV = 4, en = 1 for 12 cycles from 0.
  - count changes only on cycles 4, 8 and 12, giving 1, 2, 3.
  - Dropping en at cycle 6 for 3 cycles delays the next step by exactly 3 cycles.
- Load clamp and priority: MODULUS = 10, load_val = 4'hE asserted together with en and tick.
  - count = 9, ovf cleared, no step taken that cycle.
- Hex display: NBITS = 4, MODULUS = 16, load each value 0..15.
  - SEG[6:0] matches the table, including A = 77 and F = 71.
  - 15->0 wrap sets dp (SEG = 8'hBF).

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared hex-to-segment table, blank constant and count mode for the 7-segment blocks
package seg7_pkg;
    // gfedcba, active-high, indexed by hex digit
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7:0] SEG_BLANK = 8'h00;
    typedef enum logic {WRAP, SATURATE} count_mode_t;
endpackage

// File: rtl/seg7_counter_if.sv
// seg7_counter_if: control and status bundle of the counter
// Ports: en/up/sat/load/load_val driven by master; count/tc/ovf/SEG driven by slave
interface seg7_counter_if #(
    parameter int NBITS = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [NBITS-1:0] load_val;
    logic [NBITS-1:0] count;
    logic             tc;
    logic             ovf;
    logic [7:0]       SEG;
    modport master (output en, up, sat, load, load_val, input count, tc, ovf, SEG);
    modport slave  (input en, up, sat, load, load_val, output count, tc, ovf, SEG);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex digit plus decimal point to 8-bit segment pattern
// Ports: hex digit in, dp in, seg = {dp, gfedcba} out
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = SEG_BLANK | {dp, HEX_SEG[hex]};
endmodule

// File: rtl/seg7_counter.sv
// seg7_counter: prescaled up/down modulo counter with wrap/saturate, tc pulse, sticky ovf, hex display
// Ports: clk_2 clock, reset async active-high, bus (slave): en/up/sat/load/load_val in, count/tc/ovf/SEG out
module seg7_counter
    import seg7_pkg::*;
#(
    parameter int NBITS   = 4,
    parameter int MODULUS = 10,
    parameter int DIV     = 1
) (
    input logic           clk_2,
    input logic           reset,
    seg7_counter_if.slave bus
);
    localparam int               PW   = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [NBITS-1:0] TOP  = NBITS'(MODULUS - 1);
    localparam logic [PW-1:0]    PTOP = PW'(DIV - 1);
    logic [NBITS-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d, ovf_q, ovf_d;
    logic             tick, at_end;
    count_mode_t      mode;
    always_comb begin
        mode    = count_mode_t'(bus.sat);
        tick    = pre_q == PTOP;
        // boundary test precedes the +1/-1 so no intermediate overflow at NBITS width
        at_end  = bus.up ? count_q == TOP : count_q == '0;
        pre_d   = pre_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            pre_d   = '0;
            count_d = bus.load_val > TOP ? TOP : bus.load_val;
            ovf_d   = 1'b0;
        end else if (bus.en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick && at_end) begin
                tc_d    = 1'b1;
                ovf_d   = 1'b1;
                count_d = mode == SATURATE ? count_q : (bus.up ? '0 : TOP);
            end else if (tick) begin
                count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    seg7_decoder u_dec (
        .hex (4'(count_q)),
        .dp  (ovf_q),
        .seg (bus.SEG)
    );
endmodule

// File: tb/tb_seg7_counter.sv
// tb_seg7_counter: checks three counter configurations against a behavioural model plus directed literals
module tb_seg7_counter;
    localparam int MA [3] = '{10, 10, 16};
    localparam int DA [3] = '{1, 4, 1};
    localparam logic [7:0] HEX_T [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };
    localparam int PA [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    logic       en_a [3], up_a [3], sat_a [3], load_a [3];
    logic [3:0] lv_a [3];
    logic [3:0] cnt_a [3];
    logic       tc_a [3], ovf_a [3];
    logic [7:0] seg_a [3];
    int  m_cnt [3], m_ph [3];
    bit  m_tc [3], m_ovf [3];
    int  checks = 0, failures = 0;
    bit  run = 1'b0;
    always #5 clk_2 = ~clk_2;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        seg7_counter_if #(.NBITS(4)) bi ();
        assign bi.en       = en_a[g];
        assign bi.up       = up_a[g];
        assign bi.sat      = sat_a[g];
        assign bi.load     = load_a[g];
        assign bi.load_val = lv_a[g];
        assign cnt_a[g]    = bi.count;
        assign tc_a[g]     = bi.tc;
        assign ovf_a[g]    = bi.ovf;
        assign seg_a[g]    = bi.SEG;
        seg7_counter #(.NBITS(4), .MODULUS(MA[g]), .DIV(DA[g])) u_dut (
            .clk_2 (clk_2),
            .reset (reset),
            .bus   (bi)
        );
    end
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask
    function automatic bit past_end(int c, bit u, int m);
        int n = u ? c + 1 : c - 1;
        return n < 0 || n >= m;
    endfunction
    function automatic int next_val(int c, bit u, bit s, int m);
        int n = u ? c + 1 : c - 1;
        if (n >= 0 && n < m) return n;
        return s ? c : (n + m) % m;
    endfunction
    // model: a step happens on every DIV-th enabled cycle since reset/load
    always @(posedge clk_2 or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_cnt[k] <= 0;
                m_ph[k]  <= 0;
                m_tc[k]  <= 1'b0;
                m_ovf[k] <= 1'b0;
            end else begin
                m_tc[k] <= 1'b0;
                if (load_a[k]) begin
                    m_cnt[k] <= int'(lv_a[k]) > MA[k] - 1 ? MA[k] - 1 : int'(lv_a[k]);
                    m_ph[k]  <= 0;
                    m_ovf[k] <= 1'b0;
                end else if (en_a[k]) begin
                    m_ph[k] <= m_ph[k] + 1;
                    if ((m_ph[k] + 1) % DA[k] == 0) begin
                        m_cnt[k] <= next_val(m_cnt[k], up_a[k], sat_a[k], MA[k]);
                        if (past_end(m_cnt[k], up_a[k], MA[k])) begin
                            m_tc[k]  <= 1'b1;
                            m_ovf[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
    always @(negedge clk_2) begin
        if (run && !reset) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cmp%0d_cnt", k), cnt_a[k], m_cnt[k]);
                chk($sformatf("cmp%0d_tc", k), tc_a[k], m_tc[k]);
                chk($sformatf("cmp%0d_ovf", k), ovf_a[k], m_ovf[k]);
                chk($sformatf("cmp%0d_seg", k), seg_a[k], (m_ovf[k] ? 8'h80 : 8'h00) | HEX_T[m_cnt[k] % 16]);
            end
        end
    end
    task automatic cyc();
        @(posedge clk_2);
        #1;
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            en_a[k] = 0; up_a[k] = 1; sat_a[k] = 0; load_a[k] = 0; lv_a[k] = 0;
        end
        #12 reset = 1'b0;
        #1;
        chk("rst_cnt", cnt_a[0], 0);
        chk("rst_seg", seg_a[0], 8'h3F);
        chk("rst_ovf", ovf_a[0], 0);
        chk("rst_tc", tc_a[0], 0);
        run = 1'b1;
        cyc();
        en_a[0] = 1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("wrap_cnt%0d", i), cnt_a[0], i % 10);
        end
        chk("wrap_tc", tc_a[0], 1);
        chk("wrap_ovf", ovf_a[0], 1);
        chk("wrap_seg", seg_a[0], 8'hBF);
        cyc();
        chk("wrap_tc_clr", tc_a[0], 0);
        chk("wrap_seg1", seg_a[0], 8'h86);
        repeat (6) cyc();
        chk("pre_rst_cnt", cnt_a[0], 7);
        en_a[0] = 0;
        #3 reset = 1'b1;
        #1;
        chk("async_rst_cnt", cnt_a[0], 0);
        chk("async_rst_seg", seg_a[0], 8'h3F);
        chk("async_rst_ovf", ovf_a[0], 0);
        #2 reset = 1'b0;
        sat_a[0] = 1; up_a[0] = 0; lv_a[0] = 2; load_a[0] = 1;
        cyc();
        load_a[0] = 0;
        chk("sat_load", cnt_a[0], 2);
        en_a[0] = 1;
        cyc(); chk("sat_c1", cnt_a[0], 1); chk("sat_t1", tc_a[0], 0);
        cyc(); chk("sat_c2", cnt_a[0], 0); chk("sat_t2", tc_a[0], 0);
        cyc(); chk("sat_c3", cnt_a[0], 0); chk("sat_t3", tc_a[0], 1); chk("sat_ovf", ovf_a[0], 1);
        cyc(); chk("sat_c4", cnt_a[0], 0);
        sat_a[0] = 0;
        cyc();
        chk("dwrap_cnt", cnt_a[0], 9);
        chk("dwrap_tc", tc_a[0], 1);
        up_a[0] = 1; lv_a[0] = 4'hE; load_a[0] = 1;
        cyc();
        chk("clamp_cnt", cnt_a[0], 9);
        chk("clamp_ovf", ovf_a[0], 0);
        chk("clamp_tc", tc_a[0], 0);
        load_a[0] = 0; en_a[0] = 0;
        en_a[1] = 1;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            chk($sformatf("pre_a%0d", n), cnt_a[1], n / 4);
        end
        lv_a[1] = 0; load_a[1] = 1;
        cyc();
        load_a[1] = 0;
        chk("pre_load", cnt_a[1], 0);
        for (int n = 1; n <= 12; n++) begin
            en_a[1] = !(n >= 6 && n <= 8);
            cyc();
            chk($sformatf("pre_b%0d", n), cnt_a[1], PA[n - 1]);
        end
        en_a[1] = 0;
        for (int v = 0; v < 16; v++) begin
            lv_a[2] = 4'(v); load_a[2] = 1;
            cyc();
            chk($sformatf("hex%0d", v), seg_a[2], HEX_T[v]);
        end
        load_a[2] = 0; en_a[2] = 1;
        cyc();
        chk("hex_wrap_cnt", cnt_a[2], 0);
        chk("hex_wrap_seg", seg_a[2], 8'hBF);
        en_a[2] = 0;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
